// File: rtl/iodelay2_tap_ctrl_if.sv
// Command/status port between the tap controller and one IODELAY2 (or master/slave pair).
interface iodelay2_tap_ctrl_if;
    logic dly_cal;
    logic dly_rst;
    logic dly_ce;
    logic dly_inc;
    logic dly_busy;

    modport master (output dly_cal, output dly_rst, output dly_ce, output dly_inc, input dly_busy);
    modport slave  (input dly_cal, input dly_rst, input dly_ce, input dly_inc, output dly_busy);
endinterface

// File: rtl/iodelay2_tap_ctrl.sv
// IODELAY2 tap controller: power-up calibrate/reset, then single-tap steps with a shadow tap count.
// Optional macro IODLY_PERIODIC_CAL_EN adds automatic recalibration after RECAL_PERIOD idle cycles.
module iodelay2_tap_ctrl #(
    parameter int TAP_W        = 8,
    parameter int INIT_TAP     = 128,
    parameter int WRAP         = 1,
    parameter int GUARD        = 2,
    parameter int TIMEOUT      = 64,
    parameter int RECAL_PERIOD = 4096
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   step_req,
    input  logic                   step_inc,
    output logic                   step_rdy,
    output logic [TAP_W-1:0]       tap,
    output logic                   err,
    iodelay2_tap_ctrl_if.master    dly
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [TAP_W-1:0] TAP_MAX = '1;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_CAL       = 4'd1,
        S_CAL_WAIT  = 4'd2,
        S_RST       = 4'd3,
        S_RST_WAIT  = 4'd4,
        S_READY     = 4'd5,
        S_STEP      = 4'd6,
        S_STEP_WAIT = 4'd7,
        S_FAIL      = 4'd8
    } state_t;

    state_t             state_r, state_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic [TAP_W-1:0]   tap_s;
    logic               recal_r, recal_s;
    logic [1:0]         rst_sync_r;
    logic               run_s;
    logic               wait_done_s, wait_to_s;
    logic               expire_s, near_s;

    function automatic logic [TAP_W-1:0] tap_inc(input logic [TAP_W-1:0] t);
        if ((WRAP == 0) && (t == TAP_MAX)) return t;
        else return t + TAP_W'(1);
    endfunction

    function automatic logic [TAP_W-1:0] tap_dec(input logic [TAP_W-1:0] t);
        if ((WRAP == 0) && (t == '0)) return t;
        else return t - TAP_W'(1);
    endfunction

    // Reset release synchroniser; the FSM only leaves IDLE once this has settled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_r <= 2'b00;
        else        rst_sync_r <= {rst_sync_r[0], 1'b1};
    end

    assign run_s       = rst_sync_r[1];
    // cnt_r counts cycles since the command pulse (pulse cycle = 0)
    assign wait_done_s = (cnt_r >= CNT_W'(GUARD)) && !dly.dly_busy;
    assign wait_to_s   = (cnt_r >= CNT_W'(TIMEOUT));

`ifdef IODLY_PERIODIC_CAL_EN
    localparam int IDLE_W = (RECAL_PERIOD > 2) ? $clog2(RECAL_PERIOD) : 1;
    logic [IDLE_W-1:0] idle_r, idle_s;

    assign expire_s = (state_r == S_READY) && (idle_r == IDLE_W'(RECAL_PERIOD - 1));
    assign near_s   = (idle_s == IDLE_W'(RECAL_PERIOD - 1));

    // Idle counter: runs only while the FSM stays in READY
    always_comb begin
        idle_s = '0;
        if ((state_r == S_READY) && (state_s == S_READY)) idle_s = idle_r + IDLE_W'(1);
        else idle_s = '0;
    end

    // Idle counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) idle_r <= '0;
        else        idle_r <= idle_s;
    end
`else
    assign expire_s = 1'b0;
    assign near_s   = 1'b0;
`endif

    // Next-state, wait counter and shadow tap update
    always_comb begin
        state_s = state_r;
        cnt_s   = '0;
        tap_s   = tap;
        recal_s = recal_r;
        case (state_r)
            S_IDLE: begin
                if (start && run_s) begin state_s = S_CAL; recal_s = 1'b0; end
                else state_s = S_IDLE;
            end
            S_CAL:  begin state_s = S_CAL_WAIT; cnt_s = CNT_W'(1); end
            S_RST:  begin state_s = S_RST_WAIT; cnt_s = CNT_W'(1); end
            S_STEP: begin state_s = S_STEP_WAIT; cnt_s = CNT_W'(1); end
            S_CAL_WAIT, S_RST_WAIT, S_STEP_WAIT: begin
                cnt_s = cnt_r + CNT_W'(1);
                if (wait_done_s) begin
                    if (state_r == S_CAL_WAIT && !recal_r) begin
                        state_s = S_RST;
                        tap_s   = TAP_W'(INIT_TAP);
                    end else begin
                        state_s = S_READY;
                    end
                end else if (wait_to_s) begin
                    state_s = S_FAIL;
                end else begin
                    state_s = state_r;
                end
            end
            S_READY: begin
                if (start) begin
                    state_s = S_CAL;
                    recal_s = 1'b0;
                end else if (expire_s) begin
                    state_s = S_CAL;
                    recal_s = 1'b1;
                end else if (step_req) begin
                    state_s = S_STEP;
                    tap_s   = step_inc ? tap_inc(tap) : tap_dec(tap);
                end else begin
                    state_s = S_READY;
                end
            end
            S_FAIL: begin
                if (start) begin state_s = S_CAL; recal_s = 1'b0; end
                else state_s = S_FAIL;
            end
            default: state_s = S_IDLE;
        endcase
    end

    // State and registered outputs, all decoded from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            cnt_r       <= '0;
            recal_r     <= 1'b0;
            tap         <= '0;
            step_rdy    <= 1'b0;
            err         <= 1'b0;
            dly.dly_cal <= 1'b0;
            dly.dly_rst <= 1'b0;
            dly.dly_ce  <= 1'b0;
            dly.dly_inc <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            recal_r     <= recal_s;
            tap         <= tap_s;
            step_rdy    <= (state_s == S_READY) && !near_s;
            err         <= (state_s == S_FAIL);
            dly.dly_cal <= (state_s == S_CAL);
            dly.dly_rst <= (state_s == S_RST);
            dly.dly_ce  <= (state_s == S_STEP);
            dly.dly_inc <= (state_s == S_STEP) && step_inc;
        end
    end

endmodule
